// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, fetch FSM states and datapath widths.
package cpu_pkg;

  localparam int PC_W = 8;

  // 5-bit opcodes carried in instruction bits [8:4].
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SHL  = 5'b00101;
  localparam logic [4:0] OP_SHR  = 5'b00110;
  localparam logic [4:0] OP_LDI  = 5'b01000;
  localparam logic [4:0] OP_LD   = 5'b01001;
  localparam logic [4:0] OP_ST   = 5'b01010;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BNE  = 5'b10001;
  localparam logic [4:0] OP_JMP  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11010;
  localparam logic [4:0] OP_NOP  = 5'b11011;

  localparam logic [4:0] HALT_OP   = OP_HALT;
  localparam logic [8:0] NOP_INSTR = {OP_NOP, 4'b0000};

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic [4:0] opcode_of(input logic [8:0] instr);
    return instr[8:4];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with priority reset > load > hold > increment (wraps).
module fetch_pc_reg #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  input  logic            hold,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d, pc_q;

  // Next PC selection; increment wraps naturally at all-ones.
  always_comb begin
    pc_d = pc_q;
    if (load)       pc_d = load_pc;
    else if (!hold) pc_d = pc_q + PC_W'(1);
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, synchronous imem control and IF/ID register.
// Handshake: there is no backpressure handshake; stall=1 freezes the stage
// for that cycle, redirect_valid=1 is a one-cycle command that flushes and
// reloads the PC, and instr_valid=0 marks a bubble in IF/ID.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W      = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [8:0]      NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter logic [4:0]      HALT_OP   = cpu_pkg::HALT_OP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            go,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_en,
  input  logic [8:0]      imem_rdata,
  output logic [8:0]      instr_out,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc_out,
  output logic            halted,
  output fetch_state_t    state_dbg
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q;

  logic            inflight_vld_q, inflight_vld_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

  logic            ifid_vld_q, ifid_vld_d;
  logic [8:0]      ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;

  // advance: the pipeline moves one slot this cycle.
  logic advance, redir_take, halt_hit;
  assign advance    = (state_q == FS_RUN) && !stall && !redirect_valid;
  assign redir_take = redirect_valid && (state_q != FS_IDLE);
  // A halt only counts once it is actually latched into IF/ID.
  assign halt_hit   = advance && inflight_vld_q && (opcode_of(imem_rdata) == HALT_OP);

  fetch_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (redir_take),
    .load_pc (redirect_pc),
    .hold    (!advance || halt_hit),
    .pc      (pc_q)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FS_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: go starts, halt parks, an older redirect resumes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE:   if (go) state_d = FS_RUN;
      FS_RUN:    if (!redirect_valid && halt_hit) state_d = FS_HALTED;
      FS_HALTED: if (redirect_valid) state_d = FS_RUN;
      default:   state_d = FS_IDLE;
    endcase
  end

  // FSM outputs: memory only reads when the pipeline advances.
  always_comb begin
    imem_en = advance;
    halted  = (state_q == FS_HALTED);
  end

  // Next values for the in-flight tag and the IF/ID register.
  always_comb begin
    inflight_vld_d = inflight_vld_q;
    inflight_pc_d  = inflight_pc_q;
    ifid_vld_d     = ifid_vld_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_pc_d      = ifid_pc_q;
    if (redir_take) begin
      inflight_vld_d = 1'b0;
      ifid_vld_d     = 1'b0;
      ifid_instr_d   = NOP_INSTR;
    end else if (state_q == FS_HALTED) begin
      ifid_vld_d   = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (advance) begin
      // The fetch issued alongside a halt is dropped; PC holds on it.
      inflight_vld_d = !halt_hit;
      inflight_pc_d  = pc_q;
      ifid_vld_d     = inflight_vld_q;
      ifid_instr_d   = inflight_vld_q ? imem_rdata : NOP_INSTR;
      ifid_pc_d      = inflight_pc_q;
    end
  end

  // In-flight tag and IF/ID registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_vld_q <= 1'b0;
      inflight_pc_q  <= RESET_PC;
      ifid_vld_q     <= 1'b0;
      ifid_instr_q   <= NOP_INSTR;
      ifid_pc_q      <= '0;
    end else begin
      inflight_vld_q <= inflight_vld_d;
      inflight_pc_q  <= inflight_pc_d;
      ifid_vld_q     <= ifid_vld_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pc_q      <= ifid_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_out   = ifid_instr_q;
  assign instr_valid = ifid_vld_q;
  assign pc_out      = ifid_pc_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand sequences, random run.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, go = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic [7:0] imem_addr, pc_out;
  logic       imem_en, instr_valid, halted;
  logic [8:0] imem_rdata = '0, instr_out;
  fetch_state_t state_dbg;

  logic [8:0] mem [256];

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [8:0] NOP = 9'b110110000;
  localparam logic [8:0] HALT_INSTR = 9'b110100000;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .go             (go),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .pc_out         (pc_out),
    .halted         (halted),
    .state_dbg      (state_dbg)
  );

  // clock / synchronous-read memory
  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  typedef struct {
    logic       rst_n, go, stall, redir;
    logic [7:0] rpc;
    logic       chk_pre, exp_en;
    logic [7:0] exp_addr;
    logic       exp_vld;
    logic [8:0] exp_instr;
    logic       chk_pc;
    logic [7:0] exp_pc;
    logic       exp_halted;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic r, logic g, logic s, logic rd, logic [7:0] rpc,
                              logic cp, logic en, logic [7:0] addr,
                              logic vld, logic [8:0] ins, logic cpc, logic [7:0] pc,
                              logic h);
    vec_t v;
    v.rst_n = r; v.go = g; v.stall = s; v.redir = rd; v.rpc = rpc;
    v.chk_pre = cp; v.exp_en = en; v.exp_addr = addr;
    v.exp_vld = vld; v.exp_instr = ins; v.chk_pc = cpc; v.exp_pc = pc;
    v.exp_halted = h;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, check comb outputs before the edge
  // and registered outputs after it
  task automatic apply(input vec_t v);
    rst_n = v.rst_n; go = v.go; stall = v.stall;
    redirect_valid = v.redir; redirect_pc = v.rpc;
    #2;
    if (v.chk_pre) begin
      chk("imem_en", int'(imem_en), int'(v.exp_en));
      chk("imem_addr", int'(imem_addr), int'(v.exp_addr));
    end
    @(posedge clk); #1;
    chk("instr_valid", int'(instr_valid), int'(v.exp_vld));
    chk("instr_out", int'(instr_out), int'(v.exp_instr));
    if (v.chk_pc) chk("pc_out", int'(pc_out), int'(v.exp_pc));
    chk("halted", int'(halted), int'(v.exp_halted));
  endtask

  function automatic logic [8:0] seq_word(int a);
    return 9'(a + 1);
  endfunction

  // reference model state
  int         m_mode;   // 0 idle, 1 run, 2 halted
  logic [7:0] m_pc, m_fl_pc, m_out_pc;
  logic       m_fl_vld, m_out_vld;
  logic [8:0] m_out_instr;

  task automatic model_reset();
    m_mode = 0; m_pc = 8'h00; m_fl_vld = 1'b0; m_fl_pc = 8'h00;
    m_out_vld = 1'b0; m_out_instr = NOP; m_out_pc = 8'h00;
  endtask

  // one clock edge of the fetch stage, stated in terms of its rules
  task automatic model_step(input logic r, input logic g, input logic s,
                            input logic rd, input logic [7:0] rpc);
    if (!r) model_reset();
    else if (m_mode == 0) begin
      if (g) m_mode = 1;
    end else if (rd) begin
      m_mode = 1; m_pc = rpc; m_fl_vld = 1'b0;
      m_out_vld = 1'b0; m_out_instr = NOP;
    end else if (m_mode == 2) begin
      m_out_vld = 1'b0; m_out_instr = NOP;
    end else if (!s) begin
      m_out_vld   = m_fl_vld;
      m_out_instr = m_fl_vld ? mem[m_fl_pc] : NOP;
      m_out_pc    = m_fl_pc;
      if (m_fl_vld && mem[m_fl_pc][8:4] == 5'b11010) begin
        m_mode = 2; m_fl_vld = 1'b0;
      end else begin
        m_fl_vld = 1'b1; m_fl_pc = m_pc; m_pc = m_pc + 8'd1;
      end
    end
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) mem[i] = seq_word(i);
    @(posedge clk); #1;

    // ---- table: sequential fetch, stall, redirect under stall ----
    tbl[0]  = mk(0,0,0,0,8'h00, 0,0,8'h00, 0,NOP,1,8'h00,0);
    tbl[1]  = mk(1,1,0,0,8'h00, 1,0,8'h00, 0,NOP,0,8'h00,0);
    tbl[2]  = mk(1,0,0,0,8'h00, 1,1,8'h00, 0,NOP,0,8'h00,0);
    tbl[3]  = mk(1,0,0,0,8'h00, 1,1,8'h01, 1,9'd1,1,8'h00,0);
    tbl[4]  = mk(1,0,0,0,8'h00, 1,1,8'h02, 1,9'd2,1,8'h01,0);
    tbl[5]  = mk(1,0,0,0,8'h00, 1,1,8'h03, 1,9'd3,1,8'h02,0);
    tbl[6]  = mk(1,0,0,0,8'h00, 1,1,8'h04, 1,9'd4,1,8'h03,0);
    tbl[7]  = mk(1,0,1,0,8'h00, 1,0,8'h05, 1,9'd4,1,8'h03,0);
    tbl[8]  = mk(1,0,1,0,8'h00, 1,0,8'h05, 1,9'd4,1,8'h03,0);
    tbl[9]  = mk(1,0,1,0,8'h00, 1,0,8'h05, 1,9'd4,1,8'h03,0);
    tbl[10] = mk(1,0,0,0,8'h00, 1,1,8'h05, 1,9'd5,1,8'h04,0);
    tbl[11] = mk(1,0,0,0,8'h00, 1,1,8'h06, 1,9'd6,1,8'h05,0);
    tbl[12] = mk(1,0,1,1,8'h40, 1,0,8'h07, 0,NOP,0,8'h00,0);
    tbl[13] = mk(1,0,0,0,8'h00, 1,1,8'h40, 0,NOP,0,8'h00,0);
    tbl[14] = mk(1,0,0,0,8'h00, 1,1,8'h41, 1,9'h41,1,8'h40,0);
    tbl[15] = mk(1,0,0,0,8'h00, 1,1,8'h42, 1,9'h42,1,8'h41,0);
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
      if (i == 0) chk("state_after_reset", int'(state_dbg), int'(FS_IDLE));
      if (i == 1) chk("state_after_go", int'(state_dbg), int'(FS_RUN));
    end

    // ---- halt at address 3, stall ignored, then redirect out ----
    mem[3] = HALT_INSTR;
    apply(mk(0,0,0,0,8'h00, 0,0,8'h00, 0,NOP,1,8'h00,0));
    apply(mk(1,1,0,0,8'h00, 1,0,8'h00, 0,NOP,0,8'h00,0));
    apply(mk(1,0,0,0,8'h00, 1,1,8'h00, 0,NOP,0,8'h00,0));
    for (int c = 1; c <= 3; c++)
      apply(mk(1,0,0,0,8'h00, 1,1,8'(c), 1,seq_word(c-1),1,8'(c-1),0));
    apply(mk(1,0,0,0,8'h00, 1,1,8'h04, 1,HALT_INSTR,1,8'h03,1));
    chk("state_halted", int'(state_dbg), int'(FS_HALTED));
    apply(mk(1,0,0,0,8'h00, 1,0,8'h04, 0,NOP,0,8'h00,1));
    apply(mk(1,0,1,0,8'h00, 1,0,8'h04, 0,NOP,0,8'h00,1));
    apply(mk(1,1,0,0,8'h00, 1,0,8'h04, 0,NOP,0,8'h00,1));
    apply(mk(1,0,0,1,8'h10, 1,0,8'h04, 0,NOP,0,8'h00,0));
    apply(mk(1,0,0,0,8'h00, 1,1,8'h10, 0,NOP,0,8'h00,0));
    apply(mk(1,0,0,0,8'h00, 1,1,8'h11, 1,9'h11,1,8'h10,0));

    // ---- PC wrap, then reset mid-stream ----
    apply(mk(1,0,0,1,8'hFE, 1,0,8'h12, 0,NOP,0,8'h00,0));
    apply(mk(1,0,0,0,8'h00, 1,1,8'hFE, 0,NOP,0,8'h00,0));
    apply(mk(1,0,0,0,8'h00, 1,1,8'hFF, 1,9'hFF,1,8'hFE,0));
    apply(mk(1,0,0,0,8'h00, 1,1,8'h00, 1,9'h100,1,8'hFF,0));
    apply(mk(1,0,0,0,8'h00, 1,1,8'h01, 1,9'h001,1,8'h00,0));
    apply(mk(1,0,0,0,8'h00, 1,1,8'h02, 1,9'h002,1,8'h01,0));
    apply(mk(0,1,0,0,8'h00, 1,1,8'h03, 0,NOP,1,8'h00,0));
    chk("state_reset_mid", int'(state_dbg), int'(FS_IDLE));
    chk("addr_reset_mid", int'(imem_addr), 0);

    // ---- randomized run against the reference model ----
    for (int i = 0; i < 256; i++) mem[i] = 9'($urandom_range(0, 511));
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      v.rst_n = ($urandom_range(0, 199) != 0);
      v.go    = ($urandom_range(0, 4) == 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.redir = ($urandom_range(0, 19) == 0);
      v.rpc   = 8'($urandom_range(0, 255));
      v.chk_pre  = (cyc != 0);
      v.exp_en   = (m_mode == 1) && !v.stall && !v.redir;
      v.exp_addr = m_pc;
      if (cyc == 0) v.rst_n = 1'b0;
      model_step(v.rst_n, v.go, v.stall, v.redir, v.rpc);
      v.exp_vld    = m_out_vld;
      v.exp_instr  = m_out_instr;
      v.chk_pc     = m_out_vld;
      v.exp_pc     = m_out_pc;
      v.exp_halted = (m_mode == 2);
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
